// File: rtl/config_ramp_controller_if.sv
// ---------------------------------------------------------------------------
// config_ramp_controller_if
//   Groups the request/acknowledge handshake and the configuration output
//   bus of config_ramp_controller. The clock and reset are not part of this
//   interface; they stay plain ports on the controller.
//
//   master modport (the requester / consumer side):
//     drives  clk_en, state_select, state_req, sie_quiet
//     reads   mu_dt_bus, ca_threshold, sie_dur_bus, active_state,
//             busy, pending, state_ack
//   slave modport (the controller): the mirror image of master.
// ---------------------------------------------------------------------------
interface config_ramp_controller_if #(
  parameter int WIDTH  = 18,
  parameter int NUM_CH = 6
);
  logic                          clk_en;
  logic [2:0]                    state_select;
  logic                          state_req;
  logic                          sie_quiet;
  logic [NUM_CH*WIDTH-1:0]       mu_dt_bus;
  logic signed [WIDTH-1:0]       ca_threshold;
  logic [95:0]                   sie_dur_bus;
  logic [2:0]                    active_state;
  logic                          busy;
  logic                          pending;
  logic                          state_ack;

  modport master (
    output clk_en, state_select, state_req, sie_quiet,
    input  mu_dt_bus, ca_threshold, sie_dur_bus, active_state,
           busy, pending, state_ack
  );

  modport slave (
    input  clk_en, state_select, state_req, sie_quiet,
    output mu_dt_bus, ca_threshold, sie_dur_bus, active_state,
           busy, pending, state_ack
  );
endinterface

// File: rtl/config_ramp_controller.sv
// ---------------------------------------------------------------------------
// config_ramp_controller
//   Drives the MU (growth/dt) values of NUM_CH oscillator channels, the Ca2+
//   dendritic threshold and the six SIE phase durations for the selected
//   brain state. A state change is a request/acknowledge transaction: MU and
//   the threshold slew toward the new targets in bounded steps on each
//   clk_en tick, then the SIE durations are committed in one shot while the
//   SIE sequencer is quiescent, then state_ack pulses for one cycle.
//
//   Ports:
//     clk   - system clock
//     rst   - synchronous active-high reset
//     bus   - config_ramp_controller_if.slave:
//               clk_en       4 kHz slew strobe
//               state_select requested state code (sampled with state_req)
//               state_req    request strobe
//               sie_quiet    SIE sequencer idle/refractory
//               mu_dt_bus    packed signed MU values, channel i at [i*WIDTH +: WIDTH]
//               ca_threshold signed Q(FRAC) Ca2+ threshold
//               sie_dur_bus  {refractory, phase6..phase2}, phase2 in [15:0]
//               active_state last committed state
//               busy         transition in progress
//               pending      a queued request is waiting
//               state_ack    one-cycle commit pulse
// ---------------------------------------------------------------------------
module config_ramp_controller #(
  parameter int WIDTH     = 18,
  parameter int FRAC      = 14,
  parameter int NUM_CH    = 6,
  parameter int RAMP_STEP = 1,
  parameter int CA_STEP   = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  config_ramp_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAMP     = 2'd1,
    WAIT_SIE = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Threshold targets are simple binary fractions of one in Q(FRAC).
  localparam int CA_HALF   = 1 << (FRAC - 1);
  localparam int CA_QTR    = 1 << (FRAC - 2);
  localparam int CA_EIGHTH = 1 << (FRAC - 3);

  localparam logic signed [WIDTH:0] MU_STEP_E = (WIDTH+1)'(RAMP_STEP);
  localparam logic signed [WIDTH:0] CA_STEP_E = (WIDTH+1)'(CA_STEP);

  // -------------------------------------------------------------------------
  // Target tables
  // -------------------------------------------------------------------------

  // MU rows, one nibble per physical channel 0..5 (channel 0 in the low
  // nibble). Channels beyond the six named layers always target 3.
  function automatic logic signed [WIDTH-1:0] mu_target(input logic [2:0] s,
                                                        input int ch);
    logic [23:0]              row;
    logic signed [WIDTH-1:0]  t;
    case (s)
      3'd0:    row = 24'h333333;  // NORMAL
      3'd1:    row = 24'h112262;  // ANESTHESIA
      3'd2:    row = 24'h664424;  // PSYCHEDELIC
      3'd3:    row = 24'h446624;  // FLOW
      3'd4:    row = 24'h222244;  // MEDITATION
      default: row = 24'h444444;  // DEFAULT
    endcase
    t = '0;
    if (ch < 6) t[3:0] = row[ch*4 +: 4];
    else        t[3:0] = 4'd3;
    return t;
  endfunction

  function automatic logic signed [WIDTH-1:0] ca_target(input logic [2:0] s);
    int v;
    case (s)
      3'd1:    v = CA_HALF + CA_QTR;     // ANESTHESIA  12288
      3'd2:    v = CA_QTR;               // PSYCHEDELIC  4096
      3'd4:    v = CA_QTR + CA_EIGHTH;   // MEDITATION   6144
      default: v = CA_HALF;              // NORMAL/FLOW/DEFAULT 8192
    endcase
    return WIDTH'(v);
  endfunction

  // Packed {refractory, phase6, phase5, phase4, phase3, phase2}.
  function automatic logic [95:0] sie_target(input logic [2:0] s);
    case (s)
      3'd1:    return {16'd60000, 16'd20000, 16'd24000, 16'd8000,  16'd8000,  16'd20000};
      3'd2:    return {16'd24000, 16'd20000, 16'd48000, 16'd16000, 16'd12000, 16'd16000};
      3'd3:    return {16'd48000, 16'd12000, 16'd32000, 16'd8000,  16'd8000,  16'd12000};
      3'd4:    return {16'd32000, 16'd20000, 16'd40000, 16'd12000, 16'd12000, 16'd16000};
      default: return {16'd40000, 16'd16000, 16'd36000, 16'd10000, 16'd10000, 16'd14000};
    endcase
  endfunction

  // One bounded step toward tgt. The difference is formed one bit wider so
  // that signed extremes cannot wrap; the result lands exactly on tgt when
  // the remaining distance is within one step, so it never overshoots.
  function automatic logic signed [WIDTH-1:0] slew(
    input logic signed [WIDTH-1:0] cur,
    input logic signed [WIDTH-1:0] tgt,
    input logic signed [WIDTH:0]   step
  );
    logic signed [WIDTH:0] cur_e;
    logic signed [WIDTH:0] diff;
    cur_e = {cur[WIDTH-1], cur};
    diff  = {tgt[WIDTH-1], tgt} - cur_e;
    if (diff > step)       return WIDTH'(cur_e + step);
    else if (diff < -step) return WIDTH'(cur_e - step);
    else                   return tgt;
  endfunction

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t                   r_state;
  logic [2:0]               r_target;
  logic [2:0]               r_queued;
  logic                     r_pending;
  logic                     r_busy;
  logic                     r_ack;
  logic [2:0]               r_active;
  logic signed [WIDTH-1:0]  r_mu [NUM_CH];
  logic signed [WIDTH-1:0]  r_ca;
  logic [95:0]              r_sie;

  // -------------------------------------------------------------------------
  // Slew datapath: targets for the latched state and next-step values
  // -------------------------------------------------------------------------
  logic signed [WIDTH-1:0]  w_mu_next [NUM_CH];
  logic signed [WIDTH-1:0]  w_ca_tgt;
  logic signed [WIDTH-1:0]  w_ca_next;
  logic                     w_at_target;
  logic [NUM_CH*WIDTH-1:0]  w_mu_bus;

  always_comb begin
    w_ca_tgt    = ca_target(r_target);
    w_ca_next   = slew(r_ca, w_ca_tgt, CA_STEP_E);
    w_at_target = (r_ca == w_ca_tgt);
    w_mu_bus    = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_mu_next[ch] = slew(r_mu[ch], mu_target(r_target, ch), MU_STEP_E);
      if (r_mu[ch] != mu_target(r_target, ch)) w_at_target = 1'b0;
      w_mu_bus[ch*WIDTH +: WIDTH] = r_mu[ch];
    end
  end

  // -------------------------------------------------------------------------
  // Transition FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_target  <= 3'd0;
      r_queued  <= 3'd0;
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
      r_ack     <= 1'b0;
      r_active  <= 3'd0;
      for (int ch = 0; ch < NUM_CH; ch++) r_mu[ch] <= mu_target(3'd0, ch);
      r_ca      <= ca_target(3'd0);
      r_sie     <= sie_target(3'd0);
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.state_req) begin
            r_target <= bus.state_select;
            r_busy   <= 1'b1;
            r_state  <= RAMP;
          end
        end

        RAMP: begin
          if (bus.state_req) begin
            r_queued  <= bus.state_select;
            r_pending <= 1'b1;
          end
          // Exit is decided on the current values, so a ramp that starts on
          // target lasts exactly one cycle regardless of clk_en.
          if (w_at_target) begin
            r_state <= WAIT_SIE;
          end else if (bus.clk_en) begin
            for (int ch = 0; ch < NUM_CH; ch++) r_mu[ch] <= w_mu_next[ch];
            r_ca <= w_ca_next;
          end
        end

        WAIT_SIE: begin
          if (bus.state_req) begin
            r_queued  <= bus.state_select;
            r_pending <= 1'b1;
          end
          // All six durations change together so the sequencer never sees a
          // mix of old and new phase timings.
          if (bus.sie_quiet) begin
            r_sie    <= sie_target(r_target);
            r_active <= r_target;
            r_ack    <= 1'b1;
            r_state  <= DONE;
          end
        end

        DONE: begin
          // A request arriving now is newer than anything queued, so it
          // becomes the next target directly.
          if (bus.state_req) begin
            r_target  <= bus.state_select;
            r_pending <= 1'b0;
            r_state   <= RAMP;
          end else if (r_pending) begin
            r_target  <= r_queued;
            r_pending <= 1'b0;
            r_state   <= RAMP;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mu_dt_bus    = w_mu_bus;
  assign bus.ca_threshold = r_ca;
  assign bus.sie_dur_bus  = r_sie;
  assign bus.active_state = r_active;
  assign bus.busy         = r_busy;
  assign bus.pending      = r_pending;
  assign bus.state_ack    = r_ack;

endmodule

// File: doc/config_ramp_controller.md
Name: config_ramp_controller

Overview:
- Parametrised successor to the per-state oscillator configuration block.
- Drives MU (growth/dt) values for NUM_CH oscillator channels, the Ca2+ dendritic threshold and the SIE phase timings.
- State changes are request/acknowledge transactions. MU and threshold slew toward the new state's targets in bounded steps per clk_en tick instead of jumping, which avoids amplitude transients in the oscillator bank.
- SIE timings are committed only while the SIE sequencer is quiescent, so an in-flight ignition event never sees its phase durations change.

Parameters:
WIDTH, 18, signed fixed-point data width
FRAC, 14, fractional bits (ca_threshold is Q(FRAC))
NUM_CH, 6, number of MU channels; indices 0..5 = theta, L6, L5b, L5a, L4, L2/3; indices >=6 always target 3
RAMP_STEP, 1, maximum MU change per clk_en tick
CA_STEP, 256, maximum ca_threshold change per clk_en tick

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
clk_en  in  1  4 kHz update strobe; gates slewing only
state_select  in  3  requested state: 0 NORMAL, 1 ANESTHESIA, 2 PSYCHEDELIC, 3 FLOW, 4 MEDITATION, 5-7 DEFAULT
state_req  in  1  request strobe, sampled every clk
sie_quiet  in  1  high when SIE sequencer is idle or refractory
mu_dt_bus  out  NUM_CH*WIDTH  packed signed MU values; channel i at bits [i*WIDTH +: WIDTH]
ca_threshold  out  WIDTH  signed Ca2+ threshold
sie_dur_bus  out  96  packed {refractory, phase6, phase5, phase4, phase3, phase2}; phase2 in bits [15:0]
active_state  out  3  last fully committed state
busy  out  1  transition in progress
pending  out  1  a queued request is waiting
state_ack  out  1  one-cycle pulse on commit

Behaviour:
- Reset is synchronous on rst, per "Already decided" above; all outputs take reset values on the next clk edge:
  - MU = 3 on every channel; ca_threshold = 8192.
  - SIE durations = 14000 / 10000 / 10000 / 36000 / 16000 / 40000.
  - active_state = 0; busy, pending, state_ack = 0; FSM = IDLE; the queued request is discarded.
- Target table, MU for channels 0..5, then ca_threshold, then SIE phase2..6 and refractory:
  - NORMAL: MU 3,3,3,3,3,3; ca 8192; SIE 14000, 10000, 10000, 36000, 16000, 40000.
  - ANESTHESIA: MU 2,6,2,2,1,1; ca 12288; SIE 20000, 8000, 8000, 24000, 20000, 60000.
  - PSYCHEDELIC: MU 4,2,4,4,6,6; ca 4096; SIE 16000, 12000, 16000, 48000, 20000, 24000.
  - FLOW: MU 4,2,6,6,4,4; ca 8192; SIE 12000, 8000, 8000, 32000, 12000, 48000.
  - MEDITATION: MU 4,4,2,2,2,2; ca 6144; SIE 16000, 12000, 12000, 40000, 20000, 32000.
  - DEFAULT (codes 5-7): MU all 4; ca 8192; SIE same as NORMAL.
- FSM states are IDLE, RAMP, WAIT_SIE and DONE.
- IDLE:
  - On state_req=1, latch state_select as target and go to RAMP; busy = 1 from the next cycle.
- RAMP:
  - On each cycle with clk_en=1, each MU channel moves toward its target by min(|target-current|, RAMP_STEP).
  - ca_threshold moves toward its target by min(|diff|, CA_STEP).
  - Comparison is signed; values land exactly on target and never overshoot.
  - With clk_en=0, all values hold.
  - Exit to WAIT_SIE on the first cycle in which every MU channel and ca_threshold equal their targets, independent of clk_en. A zero-distance ramp therefore lasts one cycle.
- WAIT_SIE:
  - sie_dur_bus holds its old values.
  - In the first cycle with sie_quiet=1, load all six target durations simultaneously and go to DONE.
- DONE (one cycle):
  - state_ack = 1 and active_state = target.
  - If pending=1: load the queued state as target, clear pending, go to RAMP. busy stays 1.
  - Otherwise go to IDLE with busy = 0 from the next cycle.
- Request while busy:
  - state_req with FSM not in IDLE stores state_select in a one-deep queue and sets pending. A newer request overwrites the older one.
  - A request arriving in the same cycle as DONE is queued and then consumed immediately.
- Timing for a same-state request with sie_quiet=1:
  - Request sampled at edge 0 → RAMP in cycle 1 → WAIT_SIE in cycle 2 → DONE in cycle 3 with state_ack=1.
- state_select is ignored unless state_req=1.

Test Plan:
- Reset: assert rst for 2 cycles mid-operation → all MU = 3, ca = 8192, phase5 = 36000, refractory = 40000, busy = 0, pending = 0.
- NORMAL→ANESTHESIA with clk_en every cycle and sie_quiet=1:
  - L6 reaches 6 after 3 ticks; L2/3 reaches 1 after 2 ticks and holds.
  - ca reaches 12288 after 16 ticks.
  - state_ack fires exactly once; phase5 = 24000; active_state = 1.
- Hold sie_quiet=0 after the ramp completes → busy stays 1, phase5 stays 36000, no ack. Raise sie_quiet → next cycle phase5 = 24000 with ack.
- Request PSYCHEDELIC, then PSYCHEDELIC again and FLOW during the ramp → first ack with active_state = 2, then a ramp to FLOW (L5b = 6) and a second ack with active_state = 3. Only two acks in total.
- state_select = 7 → all MU = 4, ca = 8192, active_state = 7. Same-state repeat request → ack 3 cycles after the request.
- clk_en low for 50 cycles mid-ramp → all MU and ca values frozen. Resume clk_en → stepping continues without skipping.
